// File: rtl/noc_vc_merge_rr.sv
// noc_vc_merge_rr: round-robin wormhole merge of CHANNELS VC flit streams into one FIFO-buffered output link.
// Ports:
//   noc_clk, noc_rst_n (async active-low), i_clear (sync flush)
//   i_valid/i_flit/i_tail/o_ready : per-VC input handshake, flit of VC i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   o_valid/o_flit/o_vc_id/o_tail/i_ready : registered output handshake tagged with source VC
//   o_almost_full (count >= THRESHOLD), o_count (FIFO occupancy)
//   o_lock_timeout : sticky lock-stall watchdog flag, present only with NOC_VC_MERGE_TIMEOUT_EN defined
module noc_vc_merge_rr #(
  parameter int CHANNELS       = 4,
  parameter int FLIT_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int THRESHOLD      = DEPTH - 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             noc_clk,
  input  logic                             noc_rst_n,
  input  logic                             i_clear,
  input  logic [CHANNELS-1:0]              i_valid,
  input  logic [CHANNELS*FLIT_WIDTH-1:0]   i_flit,
  input  logic [CHANNELS-1:0]              i_tail,
  output logic [CHANNELS-1:0]              o_ready,
  output logic                             o_valid,
  output logic [FLIT_WIDTH-1:0]            o_flit,
  output logic [$clog2(CHANNELS)-1:0]      o_vc_id,
  output logic                             o_tail,
  input  logic                             i_ready,
  output logic                             o_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]       o_count,
  output logic                             o_lock_timeout
);
  localparam int VW = $clog2(CHANNELS);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = VW + 1 + FLIT_WIDTH;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [VW-1:0] ptr, ptr_n, lock_vc, lock_n, g, sel;
  logic [CW-1:0] count, count_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wdata, head, out_q, out_n;
  logic any, full, acc, rd;
  function automatic logic [VW-1:0] vc_inc(logic [VW-1:0] v);
    return (int'(v) == CHANNELS - 1) ? '0 : v + 1'b1;
  endfunction
  function automatic logic [PW-1:0] p_inc(logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // Scan downward so the valid channel closest to the pointer wins last.
  always_comb begin
    g = ptr;
    any = 1'b0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      int idx;
      idx = int'(ptr) + j;
      if (idx >= CHANNELS) idx -= CHANNELS;
      if (i_valid[idx]) begin
        g = VW'(idx);
        any = 1'b1;
      end
    end
  end
  assign full = count == CW'(DEPTH);
  assign sel = (state == LOCKED) ? lock_vc : g;
  always_comb begin
    o_ready = '0;
    if ((state == LOCKED || any) && !full) o_ready[sel] = 1'b1;
  end
  assign acc = |(i_valid & o_ready);
  assign rd = o_valid & i_ready;
  assign wdata = {sel, i_tail[sel], i_flit[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH]};
  always_comb begin
    state_n = acc ? (i_tail[sel] ? IDLE : LOCKED) : state;
    lock_n = acc ? sel : lock_vc;
    ptr_n = (acc && i_tail[sel]) ? vc_inc(sel) : ptr;
    rd_ptr_n = rd ? p_inc(rd_ptr) : rd_ptr;
    wr_ptr_n = acc ? p_inc(wr_ptr) : wr_ptr;
    count_n = count + CW'(acc) - CW'(rd);
    // When the FIFO drains to empty this cycle, the incoming flit becomes the new head directly.
    head = (count == CW'(rd)) ? wdata : mem[rd_ptr_n];
    out_n = (count_n != '0) ? head : out_q;
    if (i_clear) begin
      state_n = IDLE;
      lock_n = '0;
      ptr_n = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n = '0;
      out_n = '0;
    end
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state <= IDLE;
      lock_vc <= '0;
      ptr <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      out_q <= '0;
    end else begin
      state <= state_n;
      lock_vc <= lock_n;
      ptr <= ptr_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count <= count_n;
      out_q <= out_n;
    end
  end
  always_ff @(posedge noc_clk) begin
    if (acc) mem[wr_ptr] <= wdata;
  end
  assign {o_vc_id, o_tail, o_flit} = out_q;
  assign o_valid = count != '0;
  assign o_count = count;
  assign o_almost_full = count >= CW'(THRESHOLD);
`ifdef NOC_VC_MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic wd_flag, stall;
  assign stall = state == LOCKED && !i_valid[lock_vc];
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wd_cnt <= '0;
      wd_flag <= 1'b0;
    end else if (i_clear) begin
      wd_cnt <= '0;
      wd_flag <= 1'b0;
    end else begin
      wd_cnt <= (state != LOCKED || acc) ? '0 : (stall && wd_cnt != TW'(TIMEOUT_CYCLES)) ? wd_cnt + 1'b1 : wd_cnt;
      if (stall && wd_cnt == TW'(TIMEOUT_CYCLES - 1)) wd_flag <= 1'b1;
    end
  end
  assign o_lock_timeout = wd_flag;
`else
  assign o_lock_timeout = 1'b0;
`endif
endmodule

// File: doc/noc_vc_merge_rr.md
Name: noc_vc_merge_rr

Overview:
- Next-generation VC merge. Merges CHANNELS virtual-channel flit streams onto one output link.
- Arbitration is internal (round-robin) rather than driven by an external grant vector.
- Wormhole packet locking: once a head flit from a channel is accepted, that channel owns the output until its tail flit is accepted.
- Accepted flits pass through an internal DEPTH-entry FIFO; each flit leaves tagged with its source VC id. Sits between the router VC allocator and the output port.

Parameters:
- CHANNELS, 4: number of input VCs (≥2).
- FLIT_WIDTH, Noc_Flit_Width: flit payload width.
- DEPTH, Noc_VC_Fifo_Depth: output FIFO entries (≥2).
- THRESHOLD, DEPTH-2: occupancy at or above which o_almost_full asserts.
- TIMEOUT_CYCLES, 256: lock-stall watchdog limit (used only with the optional feature).

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous flush of FIFO, FSM, pointer and timeout flag.
- i_valid  in  CHANNELS  per-VC flit valid.
- i_flit  in  CHANNELS*FLIT_WIDTH  per-VC flit; channel i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- i_tail  in  CHANNELS  per-VC tail marker (a head with tail=1 is a single-flit packet).
- o_ready  out  CHANNELS  per-VC accept; at most one bit high.
- o_valid  out  1  output flit valid.
- o_flit  out  FLIT_WIDTH  output flit.
- o_vc_id  out  $clog2(CHANNELS)  source VC of o_flit.
- o_tail  out  1  tail marker of o_flit.
- i_ready  in  1  downstream accept.
- o_almost_full  out  1  FIFO count ≥ THRESHOLD.
- o_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- o_lock_timeout  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset (async) and i_clear (sync) both force:
  - FSM to IDLE, rr pointer to 0, FIFO empty, count 0.
  - o_valid=0, o_almost_full=0, o_lock_timeout=0; o_flit/o_vc_id/o_tail=0.
  - A partially transferred packet is discarded; its remaining flits are accepted later as if new.
- FSM states:
  - IDLE:
    - Combinational round-robin among i_valid, starting at the pointer, winner g.
    - o_ready[g]=!full; all other o_ready bits are 0.
    - Accept with i_tail[g]=0: go to LOCKED(g).
    - Accept with i_tail[g]=1: stay IDLE, pointer=g+1 mod CHANNELS.
    - No accept: pointer unchanged.
  - LOCKED(c):
    - o_ready[c]=!full; all others 0, regardless of their valids.
    - Accepting a tail from c: go to IDLE, pointer=c+1 mod CHANNELS.
    - c deasserting valid mid-packet keeps the lock.
- Acceptance occurs when i_valid[k] & o_ready[k]. The FIFO writes {k, i_tail[k], i_flit[k]}.
- FIFO:
  - Registered output. A flit accepted in cycle N is visible on o_valid/o_flit in cycle N+1 at the earliest (1-cycle latency).
  - Read occurs when o_valid & i_ready.
  - full = (count==DEPTH). No pass-through: when full, o_ready=0 even if a read happens the same cycle.
  - Simultaneous read and write when not full: count unchanged.
  - Pointers wrap modulo DEPTH; DEPTH is not required to be a power of 2.
  - Empty FIFO: o_valid=0; o_flit, o_vc_id and o_tail hold their last value.
- o_valid, once high, holds with a stable flit until i_ready (AXI-style). Valid must not drop without a handshake.
- Output order equals acceptance order; flits of one packet are contiguous on the output.

Optional Feature:
- Macro: NOC_VC_MERGE_TIMEOUT_EN.
- Defined:
  - In LOCKED(c), a counter increments on each cycle with i_valid[c]=0 and resets on any accept from c.
  - On reaching TIMEOUT_CYCLES, o_lock_timeout sets (sticky until reset or i_clear).
  - The lock is not released by the watchdog.
- Undefined: o_lock_timeout is tied 0 and no counter logic is present.

Test Plan:
- CHANNELS=4, DEPTH=4, all four VCs sending single-flit packets continuously, i_ready=1:
  - Grant order is 0,1,2,3,0,…
  - o_vc_id matches; each flit appears 1 cycle after its accept.
- VC1 sends a 3-flit packet (tail on the 3rd) while VC0 and VC2 are valid:
  - o_ready is 0b0010 for 3 accepts.
  - Output carries 3 contiguous flits with o_vc_id=1, o_tail only on the 3rd.
  - The next grant goes to VC2.
- i_ready=0 with 4 flits accepted:
  - Count reaches 4 and o_ready=0.
  - o_almost_full rises when count reaches 2.
  - Raising i_ready drains in order, count decrementing by 1 per cycle.
- Full FIFO, i_ready=1 and a pending valid in the same cycle:
  - No write that cycle.
  - Write the next cycle; count goes 4→3→4.
- Assert noc_rst_n low mid-packet (LOCKED(2), 2 flits buffered):
  - o_valid=0, count=0 immediately.
  - After release, VC0 wins first.
- With NOC_VC_MERGE_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - Lock VC3, then hold i_valid[3]=0 for 8 cycles: o_lock_timeout=1 and stays high.
  - Lock persists; i_clear drops the flag.
